// File: rtl/uci_commander_pkg.sv
// Shared types and constants for the UCI commander and its line parser.
package uci_commander_pkg;

  typedef enum logic [2:0] {
    SPECIAL_UNKNOWN        = 3'd0,
    SPECIAL_PROMOTE_KNIGHT = 3'd1,
    SPECIAL_PROMOTE_BISHOP = 3'd2,
    SPECIAL_PROMOTE_ROOK   = 3'd3,
    SPECIAL_PROMOTE_QUEEN  = 3'd4
  } special_e;

  // Files and ranks are 0-based: a/1 = 0, h/8 = 7.
  typedef struct packed {
    logic [2:0] src_fil;
    logic [2:0] src_rnk;
    logic [2:0] dst_fil;
    logic [2:0] dst_rnk;
    special_e   special;
  } move_t;

  typedef enum logic [2:0] {
    StIdle, StSendPos, StSendKw, StSendMove, StSendNl, StSendGo, StWaitBest, StDone
  } cmd_state_e;

  localparam logic [7:0] NEW_LINE = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;

  // Strings are right-aligned and zero-padded to 32 bytes so one helper can index them.
  localparam int unsigned StrBytes = 32;
  localparam logic [8*StrBytes-1:0] STR_POSITION = {{(8*15){1'b0}}, "position startpos"};
  localparam logic [8*StrBytes-1:0] STR_MOVES    = {{(8*26){1'b0}}, " moves"};
  localparam logic [8*StrBytes-1:0] STR_GO       = {{(8*30){1'b0}}, "go"};
  localparam logic [8*StrBytes-1:0] STR_BESTMOVE = {{(8*23){1'b0}}, "bestmove "};

  // Character i (0 = first) of a len-byte string constant.
  function automatic logic [7:0] str_char(input logic [8*StrBytes-1:0] s, input int unsigned len,
                                          input int unsigned i);
    return s[8*(len-1-i) +: 8];
  endfunction

  function automatic logic is_file(input logic [7:0] c);
    return (c >= "a") && (c <= "h");
  endfunction

  function automatic logic is_rank(input logic [7:0] c);
    return (c >= "1") && (c <= "8");
  endfunction

  function automatic logic [7:0] promo_char(input special_e sp);
    case (sp)
      SPECIAL_PROMOTE_KNIGHT: return "n";
      SPECIAL_PROMOTE_BISHOP: return "b";
      SPECIAL_PROMOTE_ROOK:   return "r";
      SPECIAL_PROMOTE_QUEEN:  return "q";
      default:                return 8'h00;
    endcase
  endfunction

  function automatic special_e char_promo(input logic [7:0] c);
    case (c)
      "n":     return SPECIAL_PROMOTE_KNIGHT;
      "b":     return SPECIAL_PROMOTE_BISHOP;
      "r":     return SPECIAL_PROMOTE_ROOK;
      "q":     return SPECIAL_PROMOTE_QUEEN;
      default: return SPECIAL_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/uci_commander_line_parser.sv
// uci_line_parser: buffers the head of each engine line and classifies it on newline.
module uci_line_parser
  import uci_commander_pkg::*;
#(
  parameter int unsigned LINE_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       line_done,
  output logic       is_bestmove,
  output logic       is_null,
  output logic       malformed,
  output move_t      move
);

  localparam int unsigned WinLen = 16;
  localparam int unsigned LenW   = 8;
  localparam int unsigned IdxW   = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

  logic [7:0]      line_q [LINE_LEN];
  logic [LenW-1:0] len_q;
  logic [7:0]      win [WinLen];
  logic            storing, end13, end14, end15, prefix, null_mv, coords_ok, has_promo;

  assign storing = data_valid && (data != CR) && (data != NEW_LINE) &&
                   (len_q < LenW'(LINE_LEN));

  // Line length: saturating, cleared by newline, CR ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
    end else if (data_valid && (data != CR)) begin
      if (data == NEW_LINE)  len_q <= '0;
      else if (len_q != '1) len_q <= len_q + 1'b1;
    end
  end

  // Line head storage.
  always_ff @(posedge clk) begin
    if (storing) line_q[len_q[IdxW-1:0]] <= data;
  end

  // Fixed parse window; positions past the received length read as NUL.
  for (genvar g = 0; g < WinLen; g++) begin : g_win
    if (g < LINE_LEN) begin : g_stored
      assign win[g] = (len_q > LenW'(g)) ? line_q[g] : 8'h00;
    end else begin : g_absent
      assign win[g] = 8'h00;
    end
  end

  assign end13 = (len_q == LenW'(13)) || (win[13] == " ");
  assign end14 = (len_q == LenW'(14)) || (win[14] == " ");
  assign end15 = (len_q == LenW'(15)) || (win[15] == " ");

  // Classify the buffered line; outputs qualify only with the newline byte.
  always_comb begin
    prefix    = {win[0], win[1], win[2], win[3], win[4], win[5], win[6], win[7], win[8]} ==
                STR_BESTMOVE[71:0];
    null_mv   = (({win[9], win[10], win[11], win[12]} == "0000") && end13) ||
                (({win[9], win[10], win[11], win[12], win[13], win[14]} == "(none)") && end15);
    coords_ok = is_file(win[9]) && is_rank(win[10]) && is_file(win[11]) && is_rank(win[12]);
    has_promo = (char_promo(win[13]) != SPECIAL_UNKNOWN) && end14;

    line_done   = data_valid && (data == NEW_LINE);
    is_null     = line_done && prefix && null_mv;
    is_bestmove = line_done && prefix && !null_mv;
    malformed   = is_bestmove && !(coords_ok && (end13 || has_promo));

    // 'a' and '1' both have low bits 3'b001, so the 0-based index is low bits minus one.
    move.src_fil = win[9][2:0] - 3'd1;
    move.src_rnk = win[10][2:0] - 3'd1;
    move.dst_fil = win[11][2:0] - 3'd1;
    move.dst_rnk = win[12][2:0] - 3'd1;
    move.special = has_promo ? char_promo(win[13]) : SPECIAL_UNKNOWN;
  end

endmodule

// File: rtl/uci_commander.sv
// uci_commander: UCI host initiator sending position/go and collecting bestmove replies.
// Define UCI_CMD_TIMEOUT_EN to enable the WAIT_BEST watchdog.
module uci_commander
  import uci_commander_pkg::*;
#(
  parameter int unsigned MAX_PLY        = 128,
  parameter int unsigned LINE_LEN       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         stop_in,
  output logic [7:0]                   char_out,
  output logic                         char_out_valid,
  input  logic                         char_out_ready,
  input  logic [7:0]                   char_in,
  input  logic                         char_in_valid,
  output logic                         char_in_ready,
  output move_t                        move_out,
  output logic                         move_out_valid,
  output logic [$clog2(MAX_PLY+1)-1:0] ply_count,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int unsigned PlyW = $clog2(MAX_PLY+1);
  localparam int unsigned HIdxW = (MAX_PLY > 1) ? $clog2(MAX_PLY) : 1;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  cmd_state_e      state_q, state_d;
  logic [4:0]      cidx_q, cidx_d;
  logic [PlyW-1:0] midx_q, midx_d, ply_q, ply_d, midx_nxt;
  logic            stop_q, stop_d, error_q, error_d, mv_valid_q, mv_valid_d, in_ready_q;
  move_t           move_q, move_d, cur_mv, p_move;
  move_t           hist_q [MAX_PLY];
  logic            store, last, timeout, exit_stop;
  logic            p_done, p_best, p_null, p_bad;

  uci_line_parser #(.LINE_LEN(LINE_LEN)) u_parser (
    .clk         (clk_in),
    .rst         (rst_in),
    .data        (char_in),
    .data_valid  (char_in_valid),
    .line_done   (p_done),
    .is_bestmove (p_best),
    .is_null     (p_null),
    .malformed   (p_bad),
    .move        (p_move)
  );

`ifdef UCI_CMD_TIMEOUT_EN
  localparam int unsigned TimW = $clog2(TIMEOUT_CYCLES+1);
  logic [TimW-1:0] timer_q;

  // Watchdog counts only while waiting for a reply.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                     timer_q <= '0;
    else if (state_q == StWaitBest) timer_q <= timer_q + 1'b1;
    else                            timer_q <= '0;
  end
  assign timeout = (state_q == StWaitBest) && (timer_q == TimW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign cur_mv    = hist_q[midx_q[HIdxW-1:0]];
  assign midx_nxt  = midx_q + 1'b1;
  assign exit_stop = stop_q || stop_in;

  // Next state and byte generation; transmit states advance only on a handshake.
  always_comb begin
    state_d = state_q; cidx_d = cidx_q; midx_d = midx_q; ply_d = ply_q;
    stop_d = stop_q; error_d = error_q; move_d = move_q; mv_valid_d = 1'b0;
    store = 1'b0; last = 1'b0; char_out_valid = 1'b0; char_out = 8'h00;
    if (stop_in && busy) stop_d = 1'b1;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_in) begin
          state_d = StSendPos;
          cidx_d  = '0;
        end
      end
      StSendPos: begin
        char_out_valid = 1'b1;
        char_out       = str_char(STR_POSITION, 17, 32'(cidx_q));
        if (char_out_ready) begin
          cidx_d = cidx_q + 1'b1;
          if (cidx_q == 5'd16) begin
            cidx_d  = '0;
            state_d = (ply_q == '0) ? StSendNl : StSendKw;
          end
        end
      end
      StSendKw: begin
        char_out_valid = 1'b1;
        char_out       = str_char(STR_MOVES, 6, 32'(cidx_q));
        if (char_out_ready) begin
          cidx_d = cidx_q + 1'b1;
          if (cidx_q == 5'd5) begin
            cidx_d  = '0;
            midx_d  = '0;
            state_d = StSendMove;
          end
        end
      end
      StSendMove: begin
        char_out_valid = 1'b1;
        case (cidx_q)
          5'd0:    char_out = " ";
          5'd1:    char_out = 8'h61 + {5'd0, cur_mv.src_fil};
          5'd2:    char_out = 8'h31 + {5'd0, cur_mv.src_rnk};
          5'd3:    char_out = 8'h61 + {5'd0, cur_mv.dst_fil};
          5'd4:    char_out = 8'h31 + {5'd0, cur_mv.dst_rnk};
          default: char_out = promo_char(cur_mv.special);
        endcase
        last = (cidx_q == 5'd5) || ((cidx_q == 5'd4) && (cur_mv.special == SPECIAL_UNKNOWN));
        if (char_out_ready) begin
          cidx_d = cidx_q + 1'b1;
          if (last) begin
            cidx_d = '0;
            midx_d = midx_nxt;
            if (midx_nxt == ply_q) state_d = StSendNl;
          end
        end
      end
      StSendNl: begin
        char_out_valid = 1'b1;
        char_out       = NEW_LINE;
        if (char_out_ready) state_d = StSendGo;
      end
      StSendGo: begin
        char_out_valid = 1'b1;
        char_out       = (cidx_q == 5'd2) ? NEW_LINE : str_char(STR_GO, 2, 32'(cidx_q));
        if (char_out_ready) begin
          cidx_d = cidx_q + 1'b1;
          if (cidx_q == 5'd2) begin
            cidx_d  = '0;
            state_d = StWaitBest;
          end
        end
      end
      StWaitBest: begin
        if (timeout) begin
          error_d = 1'b1;
          state_d = StDone;
          stop_d  = 1'b0;
        end else if (p_null || (p_best && (p_bad || (ply_q == PlyW'(MAX_PLY))))) begin
          if (p_bad) error_d = 1'b1;
          state_d = StDone;
          stop_d  = 1'b0;
        end else if (p_best) begin
          store      = 1'b1;
          ply_d      = ply_q + 1'b1;
          move_d     = p_move;
          mv_valid_d = 1'b1;
          cidx_d     = '0;
          state_d    = exit_stop ? StDone : StSendPos;
          stop_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      cidx_q     <= '0;
      midx_q     <= '0;
      ply_q      <= '0;
      stop_q     <= 1'b0;
      error_q    <= 1'b0;
      move_q     <= '0;
      mv_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cidx_q     <= cidx_d;
      midx_q     <= midx_d;
      ply_q      <= ply_d;
      stop_q     <= stop_d;
      error_q    <= error_d;
      move_q     <= move_d;
      mv_valid_q <= mv_valid_d;
      in_ready_q <= 1'b1;
    end
  end

  // Move history; validity is tracked by ply_q alone.
  always_ff @(posedge clk_in) begin
    if (store) hist_q[ply_q[HIdxW-1:0]] <= p_move;
  end

  assign char_in_ready  = in_ready_q;
  assign move_out       = move_q;
  assign move_out_valid = mv_valid_q;
  assign ply_count      = ply_q;
  assign busy           = (state_q != StIdle) && (state_q != StDone);
  assign done           = (state_q == StDone);
  assign error          = error_q;

endmodule

// File: doc/uci_commander.md
Name: uci_commander

Overview:
- Host-side UCI initiator. It drives the engine's character input and parses the engine's character output.
- Emits "position startpos[ moves m1 m2 ...]\n" then "go\n", waits for a "bestmove" line, and appends the returned move to an internal history. It then repeats for self-play or bench-driven games.
- Sits between an engine-side UCI handler (or UART bridge) and a game controller or test harness.

Parameters:
- MAX_PLY, 128: depth of the move history; ply_count width is $clog2(MAX_PLY+1).
- LINE_LEN, 16: number of leading characters of each received line kept for parsing.
- TIMEOUT_CYCLES, 100_000_000: watchdog limit, used only when UCI_CMD_TIMEOUT_EN is defined.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- start_in  in  1  pulse: begin or continue the game loop
- stop_in  in  1  pulse: finish the current exchange, then go DONE
- char_out  out  8  ASCII byte to the engine
- char_out_valid  out  1  char_out valid
- char_out_ready  in  1  engine accepts byte
- char_in  in  8  ASCII byte from the engine
- char_in_valid  in  1  char_in valid
- char_in_ready  out  1  always 1 (out of reset)
- move_out  out  move_t  last bestmove received
- move_out_valid  out  1  1-cycle pulse per accepted bestmove
- ply_count  out  $clog2(MAX_PLY+1)  moves in history
- busy  out  1  state != IDLE and state != DONE
- done  out  1  high in DONE
- error  out  1  sticky: malformed bestmove or timeout

Behaviour:
- Reset: all outputs 0, ply_count=0, history invalid, state=IDLE. char_out_valid drops asynchronously, even mid-character; a partially sent command is not resumed.
- Output handshake:
  - A byte transfers when char_out_valid && char_out_ready.
  - char_out must stay stable while valid is high and ready is low.
  - At most one byte per cycle; back-to-back transfers are allowed.
- States and transitions:
  - IDLE --start_in--> SEND_POS.
  - SEND_POS sends "position startpos". If ply_count==0 --> SEND_NL, else --> SEND_KW.
  - SEND_KW sends " moves", then --> SEND_MOVE with index=0.
  - SEND_MOVE sends " " + src fil ('a'+fil) + src rnk ('1'+rnk) + dst fil + dst rnk, plus n/b/r/q for SPECIAL_PROMOTE_*. It increments index; when index==ply_count --> SEND_NL.
  - SEND_NL sends 0x0A --> SEND_GO.
  - SEND_GO sends "go\n" --> WAIT_BEST; the watchdog clears here.
  - WAIT_BEST parses received lines (see parser):
    - Valid bestmove with ply_count<MAX_PLY: write move to history[ply_count], ply_count++, drive move_out and pulse move_out_valid (next cycle after the newline). Then --> SEND_POS, or --> DONE if stop is latched.
    - "bestmove 0000" or "bestmove (none)": --> DONE, ply_count unchanged, no pulse.
    - ply_count==MAX_PLY when a valid bestmove arrives: --> DONE, move not stored, no pulse.
  - DONE --start_in--> SEND_POS, which continues the game; history is kept.
- start_in in any state other than IDLE or DONE is ignored.
- stop_in latches in any busy state and takes effect at the next WAIT_BEST exit.
- Parser:
  - Always running; bytes accepted every valid cycle.
  - Keeps the first LINE_LEN bytes of each line and the line length. Further bytes are counted but not stored. 0x0D is dropped.
  - On 0x0A, the line is evaluated only in WAIT_BEST; lines in other states are discarded, as are "info ..." and all other lines.
  - A bestmove line needs prefix "bestmove ", then 4 chars, then optionally a 5th char in {n,b,r,q}, then end-of-line or a space (ponder text is ignored).
  - Files must be a..h and ranks 1..8. Otherwise error=1 --> DONE.
  - A non-promoting move gets special=SPECIAL_UNKNOWN.

Optional Feature:
- UCI_CMD_TIMEOUT_EN defined: a counter runs in WAIT_BEST. On reaching TIMEOUT_CYCLES it sets error=1 and goes --> DONE.
- Undefined: no counter logic; WAIT_BEST waits forever.

Decomposition:
- move_t and SPECIAL_* come from the shared types package.
- Add to that package:
  - The commander state enum.
  - Constants NEW_LINE=8'h0A and CR=8'h0D.
  - String constants "position startpos", " moves", "go", "bestmove ".
- One sub-module, uci_line_parser: byte stream in, per-line {is_bestmove, is_null, malformed, move_t} plus a 1-cycle line_done pulse. The FSM and the history RAM stay in uci_commander.

Test Plan:
- Reset, start_in, ready held 1: the char_out stream is exactly "position startpos\ngo\n"; busy=1, state reaches WAIT_BEST.
- Feed "info depth 3\nbestmove e2e4\n": one move_out_valid with src=(4,1), dst=(4,3), ply_count=1. Next stream is "position startpos moves e2e4\ngo\n".
- History [e2e4], feed "bestmove e7e8q ponder d1d2\n": stored special=SPECIAL_PROMOTE_QUEEN. Next command ends " e2e4 e7e8q\ngo\n".
- Toggle char_out_ready randomly (50%): the byte sequence is identical to the ready=1 case, and char_out is stable during stalls.
- Feed "bestmove 0000\n": done=1, no pulse. Feed "bestmove z9e4\n": error=1, done=1.
- Assert rst_in mid-"position": char_out_valid=0 immediately, ply_count=0. With UCI_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=50 and no input: error=1 at cycle 50 of WAIT_BEST.
